// File: rtl/addr_pipe_pkg.sv
// addr_pipe_pkg
//   Shared constants and helpers for the pipelined residue-checked adder.
//   - DEF_WIDTH / DEF_SEG / DEF_CNTW : default operand width, slice width
//                                      and error-counter width
//   - stages_f()   : number of pipeline stages for a width/slice pair
//   - mod3_f()     : mod-3 residue of an unsigned value up to RES_MAXW bits
//   - add_mod3_f() : (x + y) mod 3 for two residues
package addr_pipe_pkg;

  localparam int DEF_WIDTH  = 8;
  localparam int DEF_SEG    = 4;
  localparam int DEF_CNTW   = 4;
  localparam int DEF_STAGES = DEF_WIDTH / DEF_SEG;

  // Widest value ever reduced: a 64-bit sum plus its carry-out.
  localparam int RES_MAXW = 65;

  function automatic int stages_f(input int width, input int seg);
    return width / seg;
  endfunction

  // MSB-first Horner reduction: r <- (2*r + bit) mod 3. Leading zeros
  // leave the residue at 0, so narrower values can be zero-extended.
  function automatic logic [1:0] mod3_f(input logic [RES_MAXW-1:0] v);
    logic [1:0] r;
    r = 2'd0;
    for (int i = RES_MAXW - 1; i >= 0; i--) begin
      case ({r, v[i]})
        3'b000:  r = 2'd0;
        3'b001:  r = 2'd1;
        3'b010:  r = 2'd2;
        3'b011:  r = 2'd0;
        3'b100:  r = 2'd1;
        3'b101:  r = 2'd2;
        default: r = 2'd0;
      endcase
    end
    return r;
  endfunction

  function automatic logic [1:0] add_mod3_f(input logic [1:0] x, input logic [1:0] y);
    logic [2:0] s;
    s = {1'b0, x} + {1'b0, y};
    if (s >= 3'd3) begin
      s = s - 3'd3;
    end
    return s[1:0];
  endfunction

endpackage

// File: rtl/res_mod3.sv
// res_mod3
//   Combinational mod-3 residue of a W-bit unsigned value.
//   Ports:
//     val : input  [W-1:0]  value to reduce
//     res : output [1:0]    val mod 3
module res_mod3
  import addr_pipe_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] val,
  output logic [1:0]   res
);

  logic [RES_MAXW-1:0] val_ext;

  always_comb begin
    val_ext = '0;
    val_ext[W-1:0] = val;
    res = mod3_f(val_ext);
  end

endmodule

// File: rtl/addr_pipe_chk.sv
// addr_pipe_chk
//   Ripple-carry adder split into WIDTH/SEG pipeline stages, with a mod-3
//   residue check on the final sum and optional fault injection on bit 0.
//   Ports:
//     clk, rst           : clock, synchronous active-high reset
//     in_valid/in_ready  : operand handshake (a, b, inj_en)
//     a, b               : unsigned operands
//     inj_en             : invert sum bit 0 of this operation at the last stage
//     out_valid/out_ready: result handshake (sum, err)
//     sum                : a + b with carry-out in the MSB
//     err                : residue mismatch for the presented result
//     err_cnt            : saturating count of delivered results with err=1
module addr_pipe_chk
  import addr_pipe_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SEG   = DEF_SEG,
  parameter int CNTW  = DEF_CNTW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic            inj_en,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [WIDTH:0]  sum,
  output logic            err,
  output logic [CNTW-1:0] err_cnt
);

  localparam int STAGES = stages_f(WIDTH, SEG);

  // Replace slice idx of v with s; lower slices hold finished sum bits,
  // upper slices still hold operand A.
  function automatic logic [WIDTH-1:0] put_slice(input logic [WIDTH-1:0] v,
                                                 input logic [SEG-1:0]   s,
                                                 input int               idx);
    logic [WIDTH-1:0] r;
    r = v;
    r[idx*SEG +: SEG] = s;
    return r;
  endfunction

  logic             adv;
  logic [1:0]       res_a;
  logic [1:0]       res_b;
  logic [1:0]       res_sum;
  logic [1:0]       r_in;

  // Per-stage inputs (src_*), next values (*_d) and registers (*_q).
  logic             vld_d  [STAGES];
  logic             vld_q  [STAGES];
  logic [WIDTH-1:0] src_a  [STAGES];
  logic [WIDTH-1:0] src_b  [STAGES];
  logic             src_cy [STAGES];
  logic [WIDTH-1:0] opa_d  [STAGES];
  logic [WIDTH-1:0] opa_q  [STAGES];
  logic [WIDTH-1:0] opb_d  [STAGES];
  logic [WIDTH-1:0] opb_q  [STAGES];
  logic             cy_d   [STAGES];
  logic             cy_q   [STAGES];
  logic [1:0]       r_d    [STAGES];
  logic [1:0]       r_q    [STAGES];
  logic             inj_d  [STAGES];
  logic             inj_q  [STAGES];

  logic [WIDTH:0]   sum_d;
  logic [WIDTH:0]   sum_q;
  logic             err_d;
  logic             err_q;
  logic [CNTW-1:0]  err_cnt_d;
  logic [CNTW-1:0]  err_cnt_q;

  // The whole pipe moves as one; a held output freezes every stage.
  assign adv       = out_ready || !vld_q[STAGES-1];
  assign in_ready  = adv;
  assign out_valid = vld_q[STAGES-1];
  assign sum       = sum_q;
  assign err       = err_q;
  assign err_cnt   = err_cnt_q;

  res_mod3 #(.W(WIDTH)) u_res_a (
    .val (a),
    .res (res_a)
  );

  res_mod3 #(.W(WIDTH)) u_res_b (
    .val (b),
    .res (res_b)
  );

  res_mod3 #(.W(WIDTH + 1)) u_res_sum (
    .val (sum_d),
    .res (res_sum)
  );

  assign r_in = add_mod3_f(res_a, res_b);

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [SEG:0] slice_sum;

    if (k == 0) begin : g_head
      assign vld_d[k]  = in_valid;
      assign src_a[k]  = a;
      assign src_b[k]  = b;
      assign src_cy[k] = 1'b0;
      assign r_d[k]    = r_in;
      assign inj_d[k]  = inj_en;
    end else begin : g_body
      assign vld_d[k]  = vld_q[k-1];
      assign src_a[k]  = opa_q[k-1];
      assign src_b[k]  = opb_q[k-1];
      assign src_cy[k] = cy_q[k-1];
      assign r_d[k]    = r_q[k-1];
      assign inj_d[k]  = inj_q[k-1];
    end

    assign slice_sum = {1'b0, src_a[k][k*SEG +: SEG]}
                     + {1'b0, src_b[k][k*SEG +: SEG]}
                     + {{SEG{1'b0}}, src_cy[k]};
    assign opa_d[k]  = put_slice(src_a[k], slice_sum[SEG-1:0], k);
    assign opb_d[k]  = src_b[k];
    assign cy_d[k]   = slice_sum[SEG];
  end

  // Injection flips bit 0 ahead of the check, so an injected result always
  // changes residue and must be flagged.
  always_comb begin
    sum_d    = {cy_d[STAGES-1], opa_d[STAGES-1]};
    sum_d[0] = sum_d[0] ^ inj_d[STAGES-1];
  end

  always_comb begin
    err_d = (res_sum != r_d[STAGES-1]);
  end

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (out_valid && out_ready && err_q && (err_cnt_q != {CNTW{1'b1}})) begin
      err_cnt_d = err_cnt_q + CNTW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        vld_q[k] <= 1'b0;
      end
      sum_q     <= '0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      if (adv) begin
        for (int k = 0; k < STAGES; k++) begin
          vld_q[k] <= vld_d[k];
        end
        if (vld_d[STAGES-1]) begin
          sum_q <= sum_d;
          err_q <= err_d;
        end
      end
      err_cnt_q <= err_cnt_d;
    end
  end

  // Datapath registers need no reset: they are qualified by vld_q.
  always_ff @(posedge clk) begin
    if (adv) begin
      for (int k = 0; k < STAGES; k++) begin
        opa_q[k] <= opa_d[k];
        opb_q[k] <= opb_d[k];
        cy_q[k]  <= cy_d[k];
        r_q[k]   <= r_d[k];
        inj_q[k] <= inj_d[k];
      end
    end
  end

endmodule
